fifo_arbiter: RTL and testbench

FIFO_ARBITER -- requirements
Module: fifo_arbiter

---
 rtl/fifo_arbiter.sv | 158 +++++++++++++++
 tb/tb_fifo_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_arbiter.sv
// FIFO-ordered arbiter: requesters are queued in arrival order (lowest index wins ties)
// and granted one at a time, with a one-cycle gap after each release.
module fifo_arbiter #(
    parameter int N_REQ  = 4,
    parameter int QDEPTH = 4,
    localparam int IDW   = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1,
    localparam int CW    = $clog2(QDEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_REQ-1:0] request,
    output logic [N_REQ-1:0] grant_o,
    output logic [CW-1:0]    q_count,
    output logic             q_empty,
    output logic             q_full,
    output logic             overflow
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [N_REQ-1:0] grant_reg, grant_next;
    logic [N_REQ-1:0] grant_o_reg;
    logic [N_REQ-1:0] in_q_reg, in_q_next;
    logic [PW-1:0]    head_reg, head_next;
    logic [PW-1:0]    tail_reg, tail_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             overflow_reg, overflow_next;

    logic [IDW-1:0]   queue_mem [QDEPTH];

    logic [N_REQ-1:0] pending;
    logic [IDW-1:0]   pick_id;
    logic             pick_valid;
    logic [IDW-1:0]   head_id;
    logic             full;
    logic             pop;
    logic             push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // A requester is eligible to queue only if it is neither queued nor being served.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pending
            assign pending[gi] = request[gi] & ~in_q_reg[gi] & ~grant_reg[gi];
        end
    endgenerate

    always_comb begin
        pick_id    = '0;
        pick_valid = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pick_id    = IDW'(i);
                pick_valid = 1'b1;
            end
        end
    end

    assign head_id = queue_mem[head_reg];
    assign full    = (count_reg == CW'(QDEPTH));
    assign pop     = (state_reg == IDLE) && (count_reg != '0);
    // A pop on the same edge frees the slot, so a full queue can still accept.
    assign push    = pick_valid && (!full || pop);

    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        in_q_next     = in_q_reg;
        head_next     = head_reg;
        tail_next     = tail_reg;
        count_next    = count_reg;
        overflow_next = pick_valid && full && !pop;

        if (pop) begin
            head_next          = ptr_inc(head_reg);
            in_q_next[head_id] = 1'b0;
        end
        if (push) begin
            tail_next          = ptr_inc(tail_reg);
            in_q_next[pick_id] = 1'b1;
        end
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (pop && !push) begin
            count_next = count_reg - 1'b1;
        end

        case (state_reg)
            IDLE: begin
                // A head entry whose request has been withdrawn is simply dropped.
                if (pop && request[head_id]) begin
                    grant_next          = '0;
                    grant_next[head_id] = 1'b1;
                    state_next          = GRANT;
                end
            end
            GRANT: begin
                if ((grant_reg & request) == '0) begin
                    grant_next = '0;
                    state_next = GAP;
                end
            end
            GAP: begin
                grant_next = '0;
                state_next = IDLE;
            end
            default: begin
                grant_next = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            grant_reg    <= '0;
            grant_o_reg  <= '0;
            in_q_reg     <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            grant_reg    <= grant_next;
            grant_o_reg  <= grant_reg;
            in_q_reg     <= in_q_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            overflow_reg <= overflow_next;
        end
    end

    // Queue storage needs no reset: occupancy is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) begin
            queue_mem[tail_reg] <= pick_id;
        end
    end

    assign grant_o  = grant_o_reg;
    assign q_count  = count_reg;
    assign q_empty  = (count_reg == '0);
    assign q_full   = full;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: expected grant order is queued as stimulus is applied and
// compared whenever a new grant appears on grant_o; latency and flags checked directly.
module tb_fifo_arbiter;

    localparam int N_REQ  = 4;
    localparam int QDEPTH = 2;
    localparam int CW     = $clog2(QDEPTH + 1);

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [N_REQ-1:0] request = '0;
    logic [N_REQ-1:0] grant_o;
    logic [CW-1:0]    q_count;
    logic             q_empty;
    logic             q_full;
    logic             overflow;

    int               n_checks = 0;
    int               n_errors = 0;
    int               exp_q[$];
    logic [N_REQ-1:0] prev_grant = '0;

    fifo_arbiter #(
        .N_REQ  (N_REQ),
        .QDEPTH (QDEPTH)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .request  (request),
        .grant_o  (grant_o),
        .q_count  (q_count),
        .q_empty  (q_empty),
        .q_full   (q_full),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Grant monitor: every new non-zero grant must be one-hot and the next expected index.
    initial begin
        forever begin
            @(negedge clock);
            if (grant_o !== prev_grant) begin
                if (grant_o != '0) begin
                    check_val("grant_onehot", 32'($countones(grant_o) == 1), 32'd1);
                    if (exp_q.size() == 0) begin
                        check_val("grant_unexpected", 32'(grant_o), 32'd0);
                    end else begin
                        int e;
                        e = exp_q.pop_front();
                        check_val("grant_order", 32'(grant_o), 32'd1 << e);
                    end
                    $display("grant t=%0t grant_o=%b q_count=%0d", $time, grant_o, q_count);
                end
                prev_grant = grant_o;
            end
            if (int'(q_count) > QDEPTH) begin
                check_val("q_count_bound", 32'(q_count), 32'(QDEPTH));
            end
        end
    end

    // Plays the requesters: hold each grant 3 cycles, release, optionally re-request next cycle.
    task automatic serve(input int reraise_budget, input string tag,
                         output bit ovf_seen, output int max_cnt);
        int               held;
        int               budget;
        logic [N_REQ-1:0] dropped;
        logic [N_REQ-1:0] last;
        bit               done;
        held     = 0;
        budget   = reraise_budget;
        dropped  = '0;
        last     = '0;
        done     = 1'b0;
        ovf_seen = 1'b0;
        max_cnt  = 0;
        for (int cyc = 0; cyc < 500 && !done; cyc++) begin
            @(negedge clock);
            if (dropped != '0) begin
                request = request | dropped;
                dropped = '0;
            end
            if (overflow) ovf_seen = 1'b1;
            if (int'(q_count) > max_cnt) max_cnt = int'(q_count);
            if (grant_o == '0) held = 0;
            else if (grant_o != last) held = 1;
            else held++;
            last = grant_o;
            if (held == 3) begin
                request = request & ~grant_o;
                if (budget > 0) begin
                    dropped = grant_o;
                    budget--;
                end
                held = -1;
            end
            if (request == '0 && dropped == '0 && grant_o == '0 && q_empty) done = 1'b1;
        end
        check_val({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        bit ovf_seen;
        int max_cnt;

        tick(2);
        check_val("rst_grant_o", 32'(grant_o), 32'd0);
        check_val("rst_q_count", 32'(q_count), 32'd0);
        check_val("rst_q_empty", 32'(q_empty), 32'd1);
        check_val("rst_q_full", 32'(q_full), 32'd0);
        check_val("rst_overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        tick(1);

        // Single requester: latency in and out
        exp_q.push_back(0);
        request = 4'b0001;
        tick(1);
        check_val("s1_cnt_e1", 32'(q_count), 32'd1);
        check_val("s1_go_e1", 32'(grant_o), 32'd0);
        tick(1);
        check_val("s1_go_e2", 32'(grant_o), 32'd0);
        check_val("s1_empty_e2", 32'(q_empty), 32'd1);
        tick(1);
        check_val("s1_go_e3", 32'(grant_o), 32'b0001);
        tick(2);
        request = 4'b0000;
        tick(1);
        check_val("s1_go_ek", 32'(grant_o), 32'b0001);
        tick(1);
        check_val("s1_go_ek1", 32'(grant_o), 32'd0);
        tick(3);

        // All four at once: order 0,1,2,3 and requester 3 refused while full
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        request = 4'b1111;
        tick(1);
        check_val("s2_cnt_e1", 32'(q_count), 32'd1);
        tick(1);
        check_val("s2_cnt_e2", 32'(q_count), 32'd1);
        tick(1);
        check_val("s2_go_e3", 32'(grant_o), 32'b0001);
        check_val("s2_cnt_e3", 32'(q_count), 32'd2);
        check_val("s2_full_e3", 32'(q_full), 32'd1);
        tick(1);
        check_val("s2_overflow_e4", 32'(overflow), 32'd1);
        serve(0, "s2", ovf_seen, max_cnt);
        check_val("s2_ovf_seen", 32'(ovf_seen), 32'd1);
        check_val("s2_max_cnt", 32'(max_cnt), 32'd2);
        tick(3);

        // Withdrawal: requester 2 drops while queued, entry discarded without a grant
        exp_q.push_back(0);
        request = 4'b0101;
        tick(3);
        check_val("s3_go", 32'(grant_o), 32'b0001);
        check_val("s3_cnt_queued", 32'(q_count), 32'd1);
        request = 4'b0001;
        tick(2);
        request = 4'b0000;
        tick(1);
        check_val("s3_cnt_ek", 32'(q_count), 32'd1);
        tick(1);
        check_val("s3_cnt_gap", 32'(q_count), 32'd1);
        check_val("s3_go_gap", 32'(grant_o), 32'd0);
        tick(1);
        check_val("s3_cnt_pop", 32'(q_count), 32'd0);
        check_val("s3_empty_pop", 32'(q_empty), 32'd1);
        tick(3);
        check_val("s3_no_grant", 32'(grant_o), 32'd0);

        // Rotation: three requesters re-requesting after release, nine grants in FIFO order
        for (int k = 0; k < 9; k++) exp_q.push_back(k % 3);
        request = 4'b0111;
        serve(6, "s4", ovf_seen, max_cnt);
        check_val("s4_ovf_seen", 32'(ovf_seen), 32'd1);
        check_val("s4_max_cnt", 32'(max_cnt), 32'd2);
        tick(3);

        // Reset while requester 2 holds grant_o with two entries queued
        exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        request = 4'b0100;
        tick(2);
        request = 4'b0111;
        tick(2);
        check_val("s5_go_pre", 32'(grant_o), 32'b0100);
        check_val("s5_cnt_pre", 32'(q_count), 32'd2);
        #2 reset = 1'b0;
        #1;
        check_val("s5_rst_go", 32'(grant_o), 32'd0);
        check_val("s5_rst_cnt", 32'(q_count), 32'd0);
        check_val("s5_rst_empty", 32'(q_empty), 32'd1);
        check_val("s5_rst_full", 32'(q_full), 32'd0);
        check_val("s5_rst_ovf", 32'(overflow), 32'd0);
        tick(2);
        reset = 1'b1;
        tick(1);
        check_val("s5_cnt_e1", 32'(q_count), 32'd1);
        check_val("s5_go_e1", 32'(grant_o), 32'd0);
        tick(2);
        check_val("s5_go_e3", 32'(grant_o), 32'b0001);
        check_val("s5_cnt_e3", 32'(q_count), 32'd2);
        serve(0, "s5", ovf_seen, max_cnt);
        tick(3);

        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
